// File: rtl/line_burst_adaptor.sv
// rtl/line_burst_adaptor.sv - cache-line to multi-beat physical-memory burst adaptor
// Splits line writes into BURST_W beats and assembles read beats back into a line.
module line_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        line_addr,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [LINE_W-1:0]  line_wdata,
  output logic [LINE_W-1:0]  line_rdata,
  output logic               line_resp,
  output logic [31:0]        pmem_addr,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [BURST_W-1:0] pmem_wdata,
  input  logic [BURST_W-1:0] pmem_rdata,
  input  logic               pmem_resp
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OW    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [31:0] ADDR_MASK = ~(32'(LINE_W / 8) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LINE_W-1:0] wline_q;
  logic              read_d, write_d;
  logic              latch_addr, latch_wline, capture;
  logic              last_beat;
  logic [OW-1:0]     beat_ofs;

  assign last_beat = (cnt_q == CW'(BEATS - 1));
  assign beat_ofs  = OW'(cnt_q) * OW'(BURST_W);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_d      = pmem_read;
    write_d     = pmem_write;
    latch_addr  = 1'b0;
    latch_wline = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        // Reads win when both requests are presented together.
        if (line_read) begin
          state_d    = READ;
          cnt_d      = '0;
          read_d     = 1'b1;
          latch_addr = 1'b1;
        end else if (line_write) begin
          state_d     = WRITE;
          cnt_d       = '0;
          write_d     = 1'b1;
          latch_addr  = 1'b1;
          latch_wline = 1'b1;
        end
      end
      READ: begin
        if (pmem_resp) begin
          capture = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (last_beat) begin
            read_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (pmem_resp) begin
          cnt_d = cnt_q + CW'(1);
          if (last_beat) begin
            write_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pmem_addr  <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      line_rdata <= '0;
      wline_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pmem_read  <= read_d;
      pmem_write <= write_d;
      if (latch_addr) pmem_addr <= line_addr & ADDR_MASK;
      if (latch_wline) wline_q <= line_wdata;
      if (capture) line_rdata[beat_ofs +: BURST_W] <= pmem_rdata;
    end
  end

  // Write beat is a pure mux of the latched line so it follows the counter with no extra cycle.
  assign pmem_wdata = (state_q == WRITE) ? wline_q[beat_ofs +: BURST_W] : '0;
  assign line_resp  = (state_q == DONE);

endmodule

// File: tb/tb_line_burst_adaptor.sv
// tb/tb_line_burst_adaptor.sv - scoreboard testbench for line_burst_adaptor
module tb_line_burst_adaptor;

  localparam int LW = 256;
  localparam int BW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   line_addr = '0;
  logic          line_read = 1'b0;
  logic          line_write = 1'b0;
  logic [LW-1:0] line_wdata = '0;
  logic [LW-1:0] line_rdata;
  logic          line_resp;
  logic [31:0]   pmem_addr;
  logic          pmem_read;
  logic          pmem_write;
  logic [BW-1:0] pmem_wdata;
  logic [BW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  always #5 clk = ~clk;

  line_burst_adaptor #(.LINE_W(LW), .BURST_W(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .line_addr(line_addr), .line_read(line_read), .line_write(line_write),
    .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
    .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    bit          is_read;
    logic [31:0] addr;
    logic [63:0] wdata;
  } beat_t;

  beat_t         beat_q[$];
  logic [LW-1:0] resp_q[$];
  logic [LW-1:0] last_rd = '0;
  logic [LW-1:0] rd_line = '0;
  int            checks = 0;
  int            failures = 0;
  int            beats_seen = 0;
  int            mk = 0;
  bit            seen = 0;
  bit            gap_mode = 0;
  bit            stray = 0;
  bit            prev_line_resp = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=missing required=present", name);
  endtask

  // Memory model and monitor share one block so the monitor sees the strobe it just drove.
  always @(negedge clk) begin
    if (!rst_n) begin
      pmem_resp      = 1'b0;
      seen           = 1'b0;
      mk             = 0;
      prev_line_resp = 1'b0;
    end else begin
      if (stray) begin
        pmem_resp  = 1'b1;
        pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end else if (!(pmem_read || pmem_write)) begin
        pmem_resp = 1'b0;
        seen      = 1'b0;
        mk        = 0;
      end else begin
        if (pmem_resp) mk++;
        pmem_resp  = seen ? (gap_mode ? !pmem_resp : 1'b1) : 1'b0;
        seen       = 1'b1;
        pmem_rdata = rd_line[mk*64 +: 64];
      end

      check("pmem_mutex", LW'(pmem_read & pmem_write), '0);
      if (pmem_resp && (pmem_read || pmem_write) && !stray) begin
        if (beat_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check("beat_read", LW'(pmem_read), LW'(b.is_read));
          check("beat_write", LW'(pmem_write), LW'(!b.is_read));
          check("beat_addr", LW'(pmem_addr), LW'(b.addr));
          if (!b.is_read) check("beat_wdata", LW'(pmem_wdata), LW'(b.wdata));
        end
        beats_seen++;
      end
      if (line_resp) begin
        check("resp_single", LW'(prev_line_resp), '0);
        if (resp_q.size() == 0) fail_now("unexpected_resp");
        else check("line_rdata", line_rdata, resp_q.pop_front());
      end
      prev_line_resp = line_resp;
    end
  end

  task automatic push_read(input logic [31:0] addr, input logic [LW-1:0] line);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.is_read = 1'b1;
      b.addr    = addr & 32'hFFFF_FFE0;
      b.wdata   = '0;
      beat_q.push_back(b);
    end
    resp_q.push_back(line);
    rd_line = line;
    last_rd = line;
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [LW-1:0] line);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.is_read = 1'b0;
      b.addr    = addr & 32'hFFFF_FFE0;
      b.wdata   = line[i*64 +: 64];
      beat_q.push_back(b);
    end
    resp_q.push_back(last_rd);
  endtask

  // Called at a negedge; returns at the negedge where line_resp is seen.
  task automatic run_req(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [LW-1:0] wline, input int exp_lat, input string name);
    time t0;
    int  n;
    line_addr  = addr;
    line_wdata = wline;
    line_read  = rd;
    line_write = wr;
    t0 = $time;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!line_resp && n < 100);
    if (!line_resp) fail_now({name, "_timeout"});
    else check({name, "_latency"}, LW'(($time - t0) / 10), LW'(exp_lat));
    line_read  = 1'b0;
    line_write = 1'b0;
  endtask

  logic [LW-1:0] line_a, line_w, line_c, line_r, line_b, line_d;

  initial begin
    int n;
    int b0;
    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_w = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
              64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    line_c = {64'hA5A5_0003_A5A5_0003, 64'hA5A5_0002_A5A5_0002,
              64'hA5A5_0001_A5A5_0001, 64'hA5A5_0000_A5A5_0000};
    line_r = {64'h0BAD_0BAD_0BAD_0BAD, 64'h0BAD_0BAD_0BAD_0BAD,
              64'h0BAD_0BAD_0BAD_0BAD, 64'h0BAD_0BAD_0BAD_0BAD};
    line_b = {64'hBBBB_0003_BBBB_0003, 64'hBBBB_0002_BBBB_0002,
              64'hBBBB_0001_BBBB_0001, 64'hBBBB_0000_BBBB_0000};
    line_d = {64'h7777_6666_5555_4444, 64'h3333_2222_1111_0000,
              64'hFFFF_EEEE_DDDD_CCCC, 64'hBBBB_AAAA_9999_8888};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pmem_read", LW'(pmem_read), '0);
    check("rst_pmem_write", LW'(pmem_write), '0);
    check("rst_line_resp", LW'(line_resp), '0);
    check("rst_pmem_addr", LW'(pmem_addr), '0);
    check("rst_line_rdata", line_rdata, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read with consecutive beats
    push_read(32'h0000_1234, line_a);
    run_req(1'b1, 1'b0, 32'h0000_1234, '0, 6, "read_a");
    check("read_a_addr", LW'(pmem_addr), LW'(32'h0000_1220));
    repeat (2) @(negedge clk);

    // Write with one-cycle gaps between beats
    gap_mode = 1'b1;
    push_write(32'h0000_5678, line_w);
    run_req(1'b0, 1'b1, 32'h0000_5678, line_w, 9, "write_gap");
    repeat (2) @(negedge clk);
    gap_mode = 1'b0;

    // Simultaneous read and write: read only
    push_read(32'h0000_9ABC, line_c);
    run_req(1'b1, 1'b1, 32'h0000_9ABC, line_r, 6, "read_pri");
    check("read_pri_addr", LW'(pmem_addr), LW'(32'h0000_9AA0));
    repeat (2) @(negedge clk);

    // Reset after beat 1 of a read
    push_read(32'h0000_0100, line_d);
    line_addr = 32'h0000_0100;
    line_read = 1'b1;
    b0 = beats_seen;
    n  = 0;
    while (beats_seen < b0 + 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (beats_seen < b0 + 2) fail_now("mid_reset_beats");
    #2;
    check("pre_reset_rdata_nonzero", LW'(line_rdata != '0), LW'(1));
    rst_n     = 1'b0;
    line_read = 1'b0;
    #1;
    check("arst_pmem_read", LW'(pmem_read), '0);
    check("arst_pmem_write", LW'(pmem_write), '0);
    check("arst_line_resp", LW'(line_resp), '0);
    check("arst_pmem_addr", LW'(pmem_addr), '0);
    check("arst_line_rdata", line_rdata, '0);
    check("arst_pmem_wdata", LW'(pmem_wdata), '0);
    beat_q.delete();
    resp_q.delete();
    last_rd = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_read(32'h8000_0047, line_b);
    run_req(1'b1, 1'b0, 32'h8000_0047, '0, 6, "read_after_rst");
    check("read_after_rst_addr", LW'(pmem_addr), LW'(32'h8000_0040));
    repeat (2) @(negedge clk);

    // Stray strobe in IDLE
    @(posedge clk);
    #1 stray = 1'b1;
    repeat (3) @(posedge clk);
    #1 stray = 1'b0;
    check("stray_pmem_read", LW'(pmem_read), '0);
    check("stray_pmem_write", LW'(pmem_write), '0);
    check("stray_line_resp", LW'(line_resp), '0);
    check("stray_line_rdata", line_rdata, line_b);
    check("stray_pmem_addr", LW'(pmem_addr), LW'(32'h8000_0040));
    repeat (2) @(negedge clk);

    // Back-to-back read, write, read
    push_read(32'h0000_2FFF, line_a);
    run_req(1'b1, 1'b0, 32'h0000_2FFF, '0, 6, "b2b_read");
    push_write(32'h0000_3001, line_w);
    run_req(1'b0, 1'b1, 32'h0000_3001, line_w, 7, "b2b_write");
    push_read(32'h0000_0040, line_c);
    run_req(1'b1, 1'b0, 32'h0000_0040, '0, 7, "b2b_read2");

    repeat (4) @(negedge clk);
    check("beat_q_empty", LW'(beat_q.size()), '0);
    check("resp_q_empty", LW'(resp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_burst_adaptor.md
LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

Interface
REQ-001 SHALL have parameter: LINE_W, 256, cache-line width on the upstream (arbiter memory) side.
REQ-002 SHALL have parameter: BURST_W, 64, beat width on the physical-memory side; BEATS = LINE_W/BURST_W (4 by default), LINE_W an exact multiple of BURST_W.
REQ-003 SHALL have port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: line_addr  in  32  line request address from the bank arbiter.
REQ-006 SHALL have port: line_read  in  1  line read request, held by upstream until line_resp.
REQ-007 SHALL have port: line_write  in  1  line write request, held by upstream until line_resp.
REQ-008 SHALL have port: line_wdata  in  LINE_W  line write data.
REQ-009 SHALL have port: line_rdata  out  LINE_W  assembled read line.
REQ-010 SHALL have port: line_resp  out  1  one-cycle completion pulse.
REQ-011 SHALL have port: pmem_addr  out  32  burst address, registered.
REQ-012 SHALL have port: pmem_read  out  1  burst read request, registered.
REQ-013 SHALL have port: pmem_write  out  1  burst write request, registered.
REQ-014 SHALL have port: pmem_wdata  out  BURST_W  current write beat.
REQ-015 SHALL have port: pmem_rdata  in  BURST_W  current read beat.
REQ-016 SHALL have port: pmem_resp  in  1  beat-valid/accept strobe, one per beat; beats may be non-consecutive.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, DONE, plus a beat counter of width clog2(BEATS).
REQ-018 SHALL, in IDLE with line_read=1, latch line_addr into pmem_addr with its low clog2(LINE_W/8) bits forced to 0, clear the counter, assert pmem_read next cycle, enter READ.
REQ-019 SHALL, in IDLE with line_write=1 and line_read=0, latch line_addr (aligned) and line_wdata, clear the counter, assert pmem_write next cycle, enter WRITE.
REQ-020 SHALL give line_read priority when line_read and line_write are both 1 in IDLE.
REQ-021 SHALL, in READ, on each cycle with pmem_resp=1, store pmem_rdata into line_rdata[BURST_W*k +: BURST_W] where k = counter, then increment the counter.
REQ-022 SHALL drive pmem_wdata = latched line[BURST_W*k +: BURST_W] combinationally from counter k while in WRITE, and increment the counter on each pmem_resp=1.
REQ-023 SHALL, on the pmem_resp of beat BEATS-1, deassert pmem_read/pmem_write on the next edge and enter DONE.
REQ-024 SHALL assert line_resp only in DONE, for exactly one cycle, then return to IDLE.
REQ-025 SHALL hold line_rdata stable from DONE until the next read's first beat is captured.
REQ-026 SHALL ignore pmem_resp in IDLE and DONE, and ignore line_read/line_write in READ, WRITE, DONE.
REQ-027 SHALL, after DONE, sample requests in IDLE only, so back-to-back requests incur one IDLE cycle.
REQ-028 SHALL keep pmem_addr constant for the whole burst; latency from request sample to line_resp = BEATS + 2 cycles with no pmem_resp gaps.
REQ-029 SHALL never assert pmem_read and pmem_write in the same cycle.

Reset
REQ-030 SHALL, on rst_n=0 at any time including mid-burst, immediately enter IDLE; counter=0; pmem_read=0, pmem_write=0, line_resp=0, pmem_addr=0, line_rdata=0, latched write line=0.
REQ-031 SHALL discard a partially transferred line on reset and issue no line_resp for it.

Verification
REQ-032 SHALL pass: read addr 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> pmem_addr 0x0000_1220, line_rdata = {0x44..,0x33..,0x22..,0x11..}, line_resp one cycle, 6 cycles after request.
REQ-033 SHALL pass: write line {D3,D2,D1,D0}, pmem_resp with one-cycle gaps -> pmem_wdata shows D0,D1,D2,D3 in order, pmem_write high through beat 3, line_resp once.
REQ-034 SHALL pass: line_read and line_write both 1 in IDLE -> read burst only, pmem_write stays 0.
REQ-035 SHALL pass: rst_n low after beat 1 of a read -> all outputs 0 asynchronously; next read starts at beat 0 with a fresh line.
REQ-036 SHALL pass: stray pmem_resp in IDLE, then back-to-back read/write -> no state change from stray strobe; second request starts one cycle after first line_resp.
